// File: rtl/bus_cycle_pkg.sv
// ============================================================================
// Module   : bus_cycle_pkg
// Purpose  : Shared types and helpers for the 68k bus cycle controller.
//            Holds the cycle state encoding, the select-index width and a
//            one-hot to index converter with lowest-bit priority.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_cycle_pkg;

    // Bus cycle states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READY = 3'd2,
        ACK   = 3'd3,
        ERR   = 3'd4
    } bus_state_t;

    localparam int c_NUM_SELECTS = 8;
    localparam int c_CS_IDX_W    = $clog2(c_NUM_SELECTS);

    // Widest select vector the index helper accepts
    localparam int c_MAX_SELECTS = 32;
    localparam int c_MAX_IDX_W   = 5;

    // Index of the lowest set bit; a multi-hot vector resolves to its
    // lowest set bit, an all-zero vector returns 0.
    function automatic logic [c_MAX_IDX_W-1:0] onehot_to_idx(
        input logic [c_MAX_SELECTS-1:0] vec
    );
        logic [c_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = c_MAX_SELECTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = c_MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_timeout.sv
// ============================================================================
// Module   : bus_timeout
// Purpose  : Loadable up-counter with clear and enable. Flags expiry once the
//            count reaches TIMEOUT_CYCLES-1 and then holds there.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            clr            - force count to zero
//            en             - count one step
//            load, load_val - load an arbitrary starting count
//            expired        - count has reached TIMEOUT_CYCLES-1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timeout
    import bus_cycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               load,
    input  logic [c_CNT_W-1:0] load_val,
    output logic               expired
);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != c_LAST)) begin
            // Saturate so the expired flag stays asserted
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
// ============================================================================
// Module   : bus_cycle_ctrl
// Purpose  : 68k bus cycle controller. Latches the decoded chip select on
//            address strobe, inserts per-device wait states, optionally waits
//            for device ready, then drives DTACK. Drives BERR on an empty
//            select (and on a bus timeout when BUS_TIMEOUT_EN is defined).
// Macro    : BUS_TIMEOUT_EN - enables the TIMEOUT_CYCLES bus timeout.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            as_n         - CPU address strobe (active low, synchronised)
//            chipselects  - one-hot select from the address decoder
//            wait_cfg     - WAIT_W-bit wait count per device
//            dev_ready    - per-device ready (active high)
//            dtack_n      - data transfer acknowledge (active low)
//            berr_n       - bus error (active low)
//            cs_latched   - select held for the whole cycle, 0 when idle
//            busy         - cycle in progress
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_cycle_ctrl
    import bus_cycle_pkg::*;
#(
    parameter int                     NUM_SELECTS    = c_NUM_SELECTS,
    parameter int                     WAIT_W         = 4,
    parameter logic [NUM_SELECTS-1:0] READY_MASK     = '0,
    parameter int                     TIMEOUT_CYCLES = 256
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          as_n,
    input  logic [NUM_SELECTS-1:0]        chipselects,
    input  logic [NUM_SELECTS*WAIT_W-1:0] wait_cfg,
    input  logic [NUM_SELECTS-1:0]        dev_ready,
    output logic                          dtack_n,
    output logic                          berr_n,
    output logic [NUM_SELECTS-1:0]        cs_latched,
    output logic                          busy
);

    localparam int c_SEL_W = (NUM_SELECTS > 1) ? $clog2(NUM_SELECTS) : 1;

    bus_state_t             r_state;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [c_SEL_W-1:0]     r_sel;
    logic                   r_armed;
    logic                   r_dtack_n;
    logic                   r_berr_n;
    logic [NUM_SELECTS-1:0] r_cs_latched;
    logic                   r_busy;

    logic [c_MAX_SELECTS-1:0] w_cs_ext;
    logic [c_SEL_W-1:0]       w_new_sel;
    logic [WAIT_W-1:0]        w_new_wait;
    logic                     w_cs_any;
    logic                     w_needs_ready;
    logic                     w_sel_ready;
    logic                     w_timeout;

    assign w_cs_ext      = c_MAX_SELECTS'(chipselects);
    assign w_new_sel     = c_SEL_W'(onehot_to_idx(w_cs_ext));
    assign w_new_wait    = wait_cfg[w_new_sel*WAIT_W +: WAIT_W];
    assign w_cs_any      = |chipselects;
    assign w_needs_ready = READY_MASK[r_sel];
    assign w_sel_ready   = dev_ready[r_sel];

`ifdef BUS_TIMEOUT_EN
    logic w_to_clr;
    logic w_to_en;

    // Held clear while idle so every cycle starts counting from zero
    assign w_to_clr = (r_state == IDLE);
    assign w_to_en  = (r_state == WAIT) || (r_state == READY);

    bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_to_clr),
        .en       (w_to_en),
        .load     (1'b0),
        .load_val ('0),
        .expired  (w_timeout)
    );
`else
    // Timeout never fires in this build
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_sel        <= '0;
            r_armed      <= 1'b0;
            r_dtack_n    <= 1'b1;
            r_berr_n     <= 1'b1;
            r_cs_latched <= '0;
            r_busy       <= 1'b0;
        end else begin
            // A new cycle may only start after the strobe has been seen high
            if (as_n) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (!as_n && r_armed) begin
                        r_armed <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_cs_any) begin
                            r_state      <= WAIT;
                            r_sel        <= w_new_sel;
                            r_cs_latched <= NUM_SELECTS'(1) << w_new_sel;
                            r_wait_cnt   <= w_new_wait;
                        end else begin
                            r_state <= ERR;
                        end
                    end
                end

                WAIT: begin
                    if (as_n) begin
                        r_state      <= IDLE;
                        r_cs_latched <= '0;
                        r_busy       <= 1'b0;
                    end else if ((r_wait_cnt == '0) && !w_needs_ready) begin
                        r_state <= ACK;
                    end else if (w_timeout) begin
                        // Only a transition straight to ACK beats the timeout
                        r_state <= ERR;
                    end else if (r_wait_cnt == '0) begin
                        r_state <= READY;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end

                READY: begin
                    if (as_n) begin
                        r_state      <= IDLE;
                        r_cs_latched <= '0;
                        r_busy       <= 1'b0;
                    end else if (w_sel_ready) begin
                        r_state <= ACK;
                    end else if (w_timeout) begin
                        r_state <= ERR;
                    end
                end

                ACK: begin
                    if (as_n) begin
                        r_state      <= IDLE;
                        r_dtack_n    <= 1'b1;
                        r_cs_latched <= '0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_dtack_n <= 1'b0;
                    end
                end

                ERR: begin
                    if (as_n) begin
                        r_state      <= IDLE;
                        r_berr_n     <= 1'b1;
                        r_cs_latched <= '0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_berr_n <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_dtack_n    <= 1'b1;
                    r_berr_n     <= 1'b1;
                    r_cs_latched <= '0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign dtack_n    = r_dtack_n;
    assign berr_n     = r_berr_n;
    assign cs_latched = r_cs_latched;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
// ============================================================================
// Module   : tb_bus_cycle_ctrl
// Purpose  : Self-checking bench for bus_cycle_ctrl. A driver issues bus
//            cycles and pushes the expected acknowledge/error event into a
//            scoreboard queue; a monitor pops and compares on every falling
//            edge of dtack_n or berr_n.
// Macro    : BUS_TIMEOUT_EN - expectations follow the DUT build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_cycle_ctrl;

    localparam int         NS    = 8;
    localparam int         WW    = 4;
    localparam int         TO    = 16;
    localparam logic [7:0] RMASK = 8'b1010_0001;
    localparam int         NEVER = 32'h3fff_ffff;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          as_n;
    logic [NS-1:0] chipselects;
    logic [31:0]   wait_cfg;
    logic [NS-1:0] dev_ready;
    logic          dtack_n;
    logic          berr_n;
    logic [NS-1:0] cs_latched;
    logic          busy;

    bus_cycle_ctrl #(
        .NUM_SELECTS    (NS),
        .WAIT_W         (WW),
        .READY_MASK     (RMASK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .as_n        (as_n),
        .chipselects (chipselects),
        .wait_cfg    (wait_cfg),
        .dev_ready   (dev_ready),
        .dtack_n     (dtack_n),
        .berr_n      (berr_n),
        .cs_latched  (cs_latched),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read on falling edges only
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         kind;   // 1 = dtack, 2 = berr
        int         edge_n;
        logic [7:0] cs;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    logic prev_dtack = 1'b1;
    logic prev_berr  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic handle_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.edge_n);
            check("event_cs_latched", cs_latched, e.cs);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            check("never_both_low", {31'b0, dtack_n | berr_n}, 32'd1);
            if (prev_dtack && !dtack_n) handle_event(1);
            if (prev_berr && !berr_n) handle_event(2);
        end
        prev_dtack = dtack_n;
        prev_berr  = berr_n;
    end

    // Issue one bus cycle. rdelay: cycles from strobe-sample to first sampled
    // ready (0 = never). hold: strobe-high delay after the response (or total
    // hold when no response is expected). abort_at: raise strobe so it is
    // sampled this many cycles after start (0 = no abort).
    task automatic run_txn(input logic [7:0] cs, input logic [31:0] wcfg,
                           input int rdelay, input int hold, input int abort_at);
        int         t0, sel, w, tc, kind, ev, tr;
        logic [7:0] cs_exp;
        @(negedge clk);
        wait_cfg    = wcfg;
        chipselects = cs;
        dev_ready   = '0;
        as_n        = 1'b0;
        t0          = cyc + 1;

        // Reference model
        kind = 0; ev = 0; cs_exp = '0; sel = 0;
        if (cs == 8'h00) begin
            kind = 2;
            ev   = t0 + 1;
        end else begin
            for (int i = 7; i >= 0; i--) if (cs[i]) sel = i;
            cs_exp = 8'h01 << sel;
            w = int'(wcfg[sel*WW +: WW]);
            if (!RMASK[sel])      tc = t0 + w + 1;
            else if (rdelay == 0) tc = NEVER;
            else                  tc = (rdelay > w + 2) ? t0 + rdelay : t0 + w + 2;
            if (abort_at != 0 && t0 + abort_at <= tc && (!TO_EN || abort_at <= TO)) begin
                kind = 0;
            end else if (TO_EN && tc > t0 + TO) begin
                kind = 2;
                ev   = t0 + TO + 1;
            end else if (tc == NEVER) begin
                kind = 0;
            end else begin
                kind = 1;
                ev   = tc + 1;
            end
        end
        if (kind != 0) sb.push_back('{kind, ev, cs_exp});

        if (kind != 0)          tr = ev + hold;
        else if (abort_at != 0) tr = t0 + abort_at;
        else                    tr = t0 + hold;

        while (cyc < tr - 1) begin
            @(negedge clk);
            if (cyc == t0) begin
                check("busy_at_start", {31'b0, busy}, 32'd1);
                check("cs_latched_at_start", cs_latched, cs_exp);
            end
            if (rdelay != 0 && cyc >= t0 + rdelay - 1) dev_ready = cs_exp;
            else dev_ready = 8'($urandom) & ~cs_exp;
        end
        as_n = 1'b1;
        @(negedge clk);
        check("release_dtack_n", {31'b0, dtack_n}, 32'd1);
        check("release_berr_n", {31'b0, berr_n}, 32'd1);
        check("release_busy", {31'b0, busy}, 32'd0);
        check("release_cs_latched", cs_latched, 32'd0);
        chipselects = '0;
        dev_ready   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t0;
        logic [7:0] rcs;
        int         rsel, rdel, rhold, rab, pick;

        rst = 1'b1; as_n = 1'b1; chipselects = '0; wait_cfg = '0; dev_ready = '0;
        repeat (3) @(negedge clk);
        check("reset_dtack_n", {31'b0, dtack_n}, 32'd1);
        check("reset_berr_n", {31'b0, berr_n}, 32'd1);
        check("reset_cs_latched", cs_latched, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        run_txn(8'h04, 32'h0000_0300, 0, 2, 0);     // wait 3 on device 2
        run_txn(8'h00, 32'h1234_5678, 0, 3, 0);     // empty select
        run_txn(8'h01, 32'h0000_0000, 10, 2, 0);    // ready device, ready after 10
        run_txn(8'h01, 32'h0000_0000, 0, 1000, 0);  // ready never arrives
        run_txn(8'h10, 32'h000A_0000, 0, 1, 4);     // abort during WAIT
        run_txn(8'h06, 32'hFFFF_F5FF, 0, 2, 0);     // multi-hot resolves to device 1

        // Reset while acknowledging
        @(negedge clk);
        wait_cfg = 32'h0000_1000; chipselects = 8'h08; as_n = 1'b0; t0 = cyc + 1;
        sb.push_back('{1, t0 + 3, 8'h08});
        while (cyc < t0 + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ack_dtack_n", {31'b0, dtack_n}, 32'd1);
        check("rst_in_ack_cs_latched", cs_latched, 32'd0);
        check("rst_in_ack_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0; as_n = 1'b1; chipselects = '0;
        @(negedge clk);
        run_txn(8'h08, 32'h0000_2000, 0, 2, 0);

        // Randomised cycles
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 7);
            rsel = $urandom_range(0, 7);
            if (pick == 0)      rcs = 8'h00;
            else if (pick <= 2) rcs = 8'($urandom_range(1, 255));
            else                rcs = 8'h01 << rsel;
            rdel  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
            rhold = (rdel == 0) ? 20 : $urandom_range(1, 4);
            rab   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
            run_txn(rcs, $urandom, rdel, rhold, rab);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
